// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA draw arbiter slice.
package vga_pkg;

  localparam int unsigned X_W_DEF = 8;
  localparam int unsigned Y_W_DEF = 7;
  localparam int unsigned C_W_DEF = 3;

  // S_ prefix keeps the state names clear of the PACE parameter.
  typedef enum logic [1:0] {
    S_IDLE,
    S_PLOT,
    S_PACE
  } state_t;

  // ceil(log2(v)), never less than 1 so it can size a vector directly
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Channel-side and VGA-side signals of the draw arbiter.
interface vga_draw_arbiter_if
  import vga_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned X_W    = X_W_DEF,
  parameter int unsigned Y_W    = Y_W_DEF,
  parameter int unsigned C_W    = C_W_DEF
);
  logic [NUM_CH-1:0]     ch_req;
  logic [NUM_CH*X_W-1:0] ch_x;
  logic [NUM_CH*Y_W-1:0] ch_y;
  logic [NUM_CH*C_W-1:0] ch_color;
  logic                  vga_busy;
  logic [NUM_CH-1:0]     ch_ack;
  logic [NUM_CH-1:0]     ch_grant;
  logic [X_W-1:0]        x_out;
  logic [Y_W-1:0]        y_out;
  logic [C_W-1:0]        color_out;
  logic                  plot;

  modport master (
    output ch_req, ch_x, ch_y, ch_color, vga_busy,
    input  ch_ack, ch_grant, x_out, y_out, color_out, plot
  );

  modport slave (
    input  ch_req, ch_x, ch_y, ch_color, vga_busy,
    output ch_ack, ch_grant, x_out, y_out, color_out, plot
  );
endinterface

// File: rtl/rr_select.sv
// Circular first-requester picker starting at ptr; ptr=0 gives fixed priority.
module rr_select
  import vga_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PTR_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic              valid
);

  // walk from ptr around the ring, first asserted request wins
  always_comb begin
    int unsigned idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(ptr) + k) % NUM_CH;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the single VGA pixel port among NUM_CH drawing engines.
module vga_draw_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned X_W       = X_W_DEF,
  parameter int unsigned Y_W       = Y_W_DEF,
  parameter int unsigned C_W       = C_W_DEF,
  parameter int unsigned PACE      = 100,
  parameter int unsigned PRIO_MODE = 1,
  parameter int unsigned MAX_BURST = 0
) (
  input logic               clk,
  input logic               reset,
  vga_draw_arbiter_if.slave bus
);

  localparam int unsigned PTR_W   = clog2_min1(NUM_CH);
  localparam int unsigned PACE_W  = clog2_min1(PACE + 1);
  localparam int unsigned BURST_W = clog2_min1(MAX_BURST + 1);

  state_t              state_q, state_nx;
  logic [NUM_CH-1:0]   grant_q, grant_nx;
  logic [PTR_W-1:0]    owner_q, owner_nx;
  logic [PTR_W-1:0]    ptr_q, ptr_nx;
  logic [PACE_W-1:0]   pace_q, pace_nx;
  logic [BURST_W-1:0]  burst_q, burst_nx;
  logic [NUM_CH-1:0]   ack_q, ack_nx;
  logic                plot_q, plot_nx;
  logic [X_W-1:0]      x_q, x_nx;
  logic [Y_W-1:0]      y_q, y_nx;
  logic [C_W-1:0]      c_q, c_nx;

  logic [PTR_W-1:0]    sel_ptr;
  logic [NUM_CH-1:0]   sel_gnt;
  logic                sel_valid;
  logic [PTR_W-1:0]    sel_idx;
  logic                burst_done;
  logic                do_release;

  assign sel_ptr    = (PRIO_MODE == 0) ? '0 : ptr_q;
  assign burst_done = (MAX_BURST != 0) && (burst_q == BURST_W'(MAX_BURST));

  rr_select #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_sel (
    .req   (bus.ch_req),
    .ptr   (sel_ptr),
    .gnt   (sel_gnt),
    .valid (sel_valid)
  );

  // one-hot winner to index, kept so the owner's data slice is a plain part-select
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel_gnt[i]) sel_idx = PTR_W'(i);
    end
  end

  // next-state, pacing, burst accounting and registered pixel outputs
  always_comb begin
    state_nx   = state_q;
    grant_nx   = grant_q;
    owner_nx   = owner_q;
    ptr_nx     = ptr_q;
    pace_nx    = pace_q;
    burst_nx   = burst_q;
    ack_nx     = '0;
    plot_nx    = 1'b0;
    x_nx       = x_q;
    y_nx       = y_q;
    c_nx       = c_q;
    do_release = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          grant_nx = sel_gnt;
          owner_nx = sel_idx;
          burst_nx = '0;
          state_nx = S_PLOT;
        end
      end
      S_PLOT: begin
        // a forced release with PACE=0 lands here one cycle after the last pixel
        if (!bus.ch_req[owner_q] || burst_done) begin
          do_release = 1'b1;
        end else if (!bus.vga_busy) begin
          x_nx            = bus.ch_x[32'(owner_q) * X_W +: X_W];
          y_nx            = bus.ch_y[32'(owner_q) * Y_W +: Y_W];
          c_nx            = bus.ch_color[32'(owner_q) * C_W +: C_W];
          plot_nx         = 1'b1;
          ack_nx[owner_q] = 1'b1;
          if (burst_q != '1) burst_nx = burst_q + 1'b1;
          if (PACE != 0) begin
            state_nx = S_PACE;
            pace_nx  = PACE_W'(PACE - 1);
          end
        end
      end
      S_PACE: begin
        if (pace_q == '0) begin
          if (burst_done) do_release = 1'b1;
          else            state_nx   = S_PLOT;
        end else begin
          pace_nx = pace_q - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (do_release) begin
      grant_nx = '0;
      state_nx = S_IDLE;
      ptr_nx   = (owner_q == PTR_W'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      pace_q  <= '0;
      burst_q <= '0;
      ack_q   <= '0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_nx;
      grant_q <= grant_nx;
      owner_q <= owner_nx;
      ptr_q   <= ptr_nx;
      pace_q  <= pace_nx;
      burst_q <= burst_nx;
      ack_q   <= ack_nx;
      plot_q  <= plot_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      c_q     <= c_nx;
    end
  end

  assign bus.ch_grant  = grant_q;
  assign bus.ch_ack    = ack_q;
  assign bus.plot      = plot_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.color_out = c_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench: A = RR/PACE 2, B = fixed priority/PACE 2, C = RR/PACE 0/MAX_BURST 3.
module tb_vga_draw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] xs;
  logic [27:0] ys;
  logic [11:0] cs;
  logic        busy;
  int unsigned sel;

  int errors = 0;
  int checks = 0;

  int unsigned exp_q[$];
  int          rem[4];
  int unsigned mb_ch[12]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  int unsigned mb_cyc[12] = '{2, 3, 4, 7, 8, 9, 12, 13, 14, 17, 18, 19};

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] ack;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } snap_t;

  always #5 clk = ~clk;

  vga_draw_arbiter_if #(.NUM_CH(4), .X_W(8), .Y_W(7), .C_W(3)) if_a ();
  vga_draw_arbiter_if #(.NUM_CH(4), .X_W(8), .Y_W(7), .C_W(3)) if_b ();
  vga_draw_arbiter_if #(.NUM_CH(4), .X_W(8), .Y_W(7), .C_W(3)) if_c ();

  assign if_a.ch_req = req;  assign if_a.ch_x = xs;  assign if_a.ch_y = ys;
  assign if_a.ch_color = cs; assign if_a.vga_busy = busy;
  assign if_b.ch_req = req;  assign if_b.ch_x = xs;  assign if_b.ch_y = ys;
  assign if_b.ch_color = cs; assign if_b.vga_busy = busy;
  assign if_c.ch_req = req;  assign if_c.ch_x = xs;  assign if_c.ch_y = ys;
  assign if_c.ch_color = cs; assign if_c.vga_busy = busy;

  vga_draw_arbiter #(.NUM_CH(4), .X_W(8), .Y_W(7), .C_W(3),
                     .PACE(2), .PRIO_MODE(1), .MAX_BURST(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  vga_draw_arbiter #(.NUM_CH(4), .X_W(8), .Y_W(7), .C_W(3),
                     .PACE(2), .PRIO_MODE(0), .MAX_BURST(0))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  vga_draw_arbiter #(.NUM_CH(4), .X_W(8), .Y_W(7), .C_W(3),
                     .PACE(0), .PRIO_MODE(1), .MAX_BURST(3))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));

  function automatic snap_t snap();
    snap_t s;
    case (sel)
      0:       s = {if_a.ch_grant, if_a.ch_ack, if_a.plot, if_a.x_out, if_a.y_out, if_a.color_out};
      1:       s = {if_b.ch_grant, if_b.ch_ack, if_b.plot, if_b.x_out, if_b.y_out, if_b.color_out};
      default: s = {if_c.ch_grant, if_c.ch_ack, if_c.plot, if_c.x_out, if_c.y_out, if_c.color_out};
    endcase
    return s;
  endfunction

  function automatic int unsigned oh2idx(input logic [3:0] v);
    int unsigned r;
    r = 99;
    for (int i = 0; i < 4; i++) if (v[i]) r = 32'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    xs[i*8 +: 8] = x;
    ys[i*7 +: 7] = y;
    cs[i*3 +: 3] = c;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    req   = '0;
    busy  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // serve per-channel pixel counts in rem[], re-requesting only while idle
  task automatic run_order(input string tag);
    int unsigned idx, cyc, got;
    snap_t s;
    idx = 0;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 400) begin
      s = snap();
      if (s.grant == 4'b0000)
        for (int i = 0; i < 4; i++) req[i] = (rem[i] > 0);
      tick();
      cyc++;
      s = snap();
      if (s.ack != 4'b0000) begin
        got = oh2idx(s.ack);
        chk({tag, "_order"}, 32'(got), 32'(exp_q[idx]));
        chk({tag, "_grant"}, 32'(s.grant), 32'(4'b0001 << exp_q[idx]));
        chk({tag, "_x"}, 32'(s.x), 32'(exp_q[idx] * 16 + 3));
        if (got < 4) begin
          rem[got]--;
          req[got] = 1'b0;
        end
        idx++;
      end
    end
    chk({tag, "_count"}, 32'(idx), 32'(exp_q.size()));
    req = '0;
    cyc = 0;
    while (snap().grant != 4'b0000 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk({tag, "_idle"}, 32'(snap().grant), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    snap_t s;
    int unsigned idx;
    reset = 1'b1; req = '0; busy = 1'b0; xs = '0; ys = '0; cs = '0; sel = 0;
    tick();
    tick();
    for (int unsigned k = 0; k < 3; k++) begin
      sel = k;
      chk("reset_state", 32'(snap()), 32'd0);
    end
    reset = 1'b0;
    sel   = 0;
    tick();

    // single channel, PACE=2
    set_ch(1, 8'd10, 7'd20, 3'd5);
    req[1] = 1'b1;
    tick(); s = snap();
    chk("single_grant_c1", 32'(s.grant), 32'(4'b0010));
    chk("single_noplot_c1", 32'(s.plot), 32'd0);
    tick(); s = snap();
    chk("single_plot_c2", 32'(s.plot), 32'd1);
    chk("single_ack_c2", 32'(s.ack), 32'(4'b0010));
    chk("single_xyc_c2", {s.x, s.y, s.c}, {8'd10, 7'd20, 3'd5});
    set_ch(1, 8'd11, 7'd21, 3'd4);
    tick(); s = snap();
    chk("single_noplot_c3", 32'({s.plot, s.ack}), 32'd0);
    tick(); s = snap();
    chk("single_noplot_c4", 32'({s.plot, s.ack}), 32'd0);
    chk("single_hold_c4", 32'(s.x), 32'd10);
    tick(); s = snap();
    chk("single_plot_c5", 32'(s.plot), 32'd1);
    chk("single_x_c5", 32'(s.x), 32'd11);
    req[1] = 1'b0;
    tick(); tick(); s = snap();
    chk("single_grant_c7", 32'(s.grant), 32'(4'b0010));
    tick(); s = snap();
    chk("single_release_c8", 32'(s.grant), 32'd0);

    // vga_busy for 4 PLOT cycles
    busy = 1'b1;
    set_ch(2, 8'd30, 7'd40, 3'd6);
    req[2] = 1'b1;
    tick(); s = snap();
    chk("busy_grant", 32'(s.grant), 32'(4'b0100));
    for (int k = 0; k < 4; k++) begin
      tick(); s = snap();
      chk("busy_noplot", 32'({s.plot, s.ack}), 32'd0);
      chk("busy_hold", {s.grant, s.x, s.y, s.c}, {4'b0100, 8'd11, 7'd21, 3'd4});
    end
    busy = 1'b0;
    tick(); s = snap();
    chk("busy_plot_after", 32'({s.plot, s.ack}), 32'({1'b1, 4'b0100}));
    chk("busy_xyc_after", {s.x, s.y, s.c}, {8'd30, 7'd40, 3'd6});
    req[2] = 1'b0;
    tick(); tick(); tick(); s = snap();
    chk("busy_release", 32'(s.grant), 32'd0);

    // reset mid-PACE while ch2 owns (pointer is 3 here)
    set_ch(2, 8'd50, 7'd60, 3'd7);
    req[2] = 1'b1;
    tick(); tick(); s = snap();
    chk("rst_pre_plot", 32'(s.x), 32'd50);
    tick(); s = snap();
    chk("rst_pre_pace_grant", 32'({s.grant, s.plot}), 32'({4'b0100, 1'b0}));
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", 32'(snap()), 32'd0);
    req = '0;
    tick();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) set_ch(i, 8'(i * 16 + 3), 7'(i * 8 + 1), 3'(i + 1));

    // A: round-robin
    rem = '{1, 1, 1, 1}; exp_q = '{0, 1, 2, 3};
    run_order("rr_all");
    rem = '{2, 0, 2, 0}; exp_q = '{0, 2, 0, 2};
    run_order("rr_02");

    // B: fixed priority
    sel = 1;
    rst_pulse();
    rem = '{1, 1, 1, 1}; exp_q = '{0, 1, 2, 3};
    run_order("fx_all");
    rem = '{2, 0, 2, 0}; exp_q = '{0, 0, 2, 2};
    run_order("fx_02");

    // C: burst limit 3, back-to-back, ch0 and ch1 hold requests
    sel = 2;
    rst_pulse();
    req = 4'b0011;
    idx = 0;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      tick(); s = snap();
      if (s.ack != 4'b0000 && idx < 12) begin
        chk("burst_channel", 32'(oh2idx(s.ack)), 32'(mb_ch[idx]));
        chk("burst_cycle", 32'(cyc), 32'(mb_cyc[idx]));
        idx++;
      end
      if (cyc == 5 || cyc == 10 || cyc == 15) chk("burst_release", 32'(s.grant), 32'd0);
    end
    chk("burst_count", 32'(idx), 32'd12);
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
